cycle_sequencer: RTL and testbench

Phase controller that sits directly around the 1 Hz seconds counter. It loads the counter's target duration, gates its tick, and restarts it at each phase boundary. It consumes the counter's expiry signal to step through three timed phases (5, 7 and 8 minutes by default). It is the block the user-facing start/pause/abort controls talk to, and it reports phase, busy and completion to the display and top level.

---
 rtl/cycle_seq_pkg.sv | 24 ++
 rtl/seconds_left_counter.sv | 40 ++++
 rtl/cycle_sequencer.sv | 123 ++++++++++++
 tb/tb_cycle_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_seq_pkg.sv
// Shared types and constants for the cycle sequencer and its remaining-time counter.
package cycle_seq_pkg;

    localparam int unsigned DUR_W           = 10;
    localparam int unsigned PHASE_W         = 3;
    localparam int unsigned DEF_PHASE_A_SEC = 300;
    localparam int unsigned DEF_PHASE_B_SEC = 420;
    localparam int unsigned DEF_PHASE_C_SEC = 480;

    // Encodings double as the externally visible phase number.
    typedef enum logic [PHASE_W-1:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        DONE = 3'd4
    } state_e;

    // True while a timed phase is running.
    function automatic logic is_busy(input state_e s);
        return (s == PH_A) || (s == PH_B) || (s == PH_C);
    endfunction

endpackage

// File: rtl/seconds_left_counter.sv
// Loadable 10-bit down-counter that saturates at zero; clear beats load beats decrement.
module seconds_left_counter
    import cycle_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [DUR_W-1:0] load_val_i,
    output logic [DUR_W-1:0] count_o
);

    logic [DUR_W-1:0] count_q;
    logic [DUR_W-1:0] count_d;

    // Next count: clear, reload on phase entry, or saturating decrement.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - DUR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cycle_sequencer.sv
// Three-phase sequencer wrapped around the 1 Hz seconds counter: loads the
// phase duration, gates the counter tick and restarts it at phase boundaries.
// Optional remaining-time readout enabled by defining REMAINING_TIME_EN.
module cycle_sequencer
    import cycle_seq_pkg::*;
#(
    parameter int unsigned PHASE_A_SEC = DEF_PHASE_A_SEC,
    parameter int unsigned PHASE_B_SEC = DEF_PHASE_B_SEC,
    parameter int unsigned PHASE_C_SEC = DEF_PHASE_C_SEC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic               phase_expire,
    output logic [DUR_W-1:0]   counter_seconds,
    output logic               cnt_tick,
    output logic               cnt_rst,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               done,
    output logic [DUR_W-1:0]   seconds_left
);

    state_e           state_q, state_d;
    logic [DUR_W-1:0] cs_q, cs_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             advance_c;

    function automatic state_e next_phase(input state_e s);
        case (s)
            PH_A:    return PH_B;
            PH_B:    return PH_C;
            PH_C:    return DONE;
            default: return s;
        endcase
    endfunction

    function automatic logic [DUR_W-1:0] phase_duration(input state_e s);
        case (s)
            PH_A:    return DUR_W'(PHASE_A_SEC);
            PH_B:    return DUR_W'(PHASE_B_SEC);
            PH_C:    return DUR_W'(PHASE_C_SEC);
            default: return '0;
        endcase
    endfunction

    // Ticks reaching the counter are dropped while idle, paused or restarting.
    assign cnt_tick  = tick & busy_q & ~pause & ~cnt_rst_q;
    assign advance_c = cnt_tick & phase_expire;

    // Next state and next registered outputs; abort > advance > start.
    always_comb begin
        state_d   = state_q;
        cnt_rst_d = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            state_d   = IDLE;
            cnt_rst_d = 1'b1;
        end else if (advance_c) begin
            state_d   = next_phase(state_q);
            cnt_rst_d = 1'b1;
            done_d    = (state_q == PH_C);
        end else if (start && !busy_q) begin
            state_d   = PH_A;
            cnt_rst_d = 1'b1;
        end
        busy_d = is_busy(state_d);
        if (!busy_d) begin
            cnt_rst_d = 1'b1;
        end
        cs_d = phase_duration(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cs_q      <= '0;
            cnt_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            cnt_rst_q <= cnt_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign phase           = state_q;
    assign counter_seconds = cs_q;
    assign cnt_rst         = cnt_rst_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef REMAINING_TIME_EN
    logic sl_load_c;
    logic sl_clr_c;

    // Reload on every phase entry, clear whenever no phase is running.
    assign sl_load_c = busy_d & cnt_rst_d;
    assign sl_clr_c  = ~busy_d;

    seconds_left_counter u_seconds_left (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (sl_clr_c),
        .load_i     (sl_load_c),
        .dec_i      (cnt_tick),
        .load_val_i (cs_d),
        .count_o    (seconds_left)
    );
`else
    assign seconds_left = '0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer with 3/4/5 second phases and a
// behavioural model of the seconds counter feeding phase_expire.
module tb_cycle_sequencer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       pause;
    logic       abort;
    logic       phase_expire;
    logic [9:0] counter_seconds;
    logic       cnt_tick;
    logic       cnt_rst;
    logic [2:0] phase;
    logic       busy;
    logic       done;
    logic [9:0] seconds_left;

    int checks   = 0;
    int failures = 0;
    logic ct_seen;

    cycle_sequencer #(
        .PHASE_A_SEC (3),
        .PHASE_B_SEC (4),
        .PHASE_C_SEC (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .start           (start),
        .pause           (pause),
        .abort           (abort),
        .phase_expire    (phase_expire),
        .counter_seconds (counter_seconds),
        .cnt_tick        (cnt_tick),
        .cnt_rst         (cnt_rst),
        .phase           (phase),
        .busy            (busy),
        .done            (done),
        .seconds_left    (seconds_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural seconds counter: wraps at counter_seconds, expiry on last count.
    logic [9:0] model_cnt;
    always_ff @(posedge clk) begin
        if (cnt_rst) begin
            model_cnt <= '0;
        end else if (cnt_tick) begin
            model_cnt <= (model_cnt == counter_seconds - 10'd1) ? 10'd0 : model_cnt + 10'd1;
        end
    end
    assign phase_expire = (counter_seconds != 10'd0) && (model_cnt == counter_seconds - 10'd1);

    typedef struct {
        logic       tick;
        logic       start;
        logic       pause;
        logic       abort;
        logic       ct;
        logic [2:0] ph;
        logic [9:0] cs;
        logic       rst;
        logic       busy;
        logic       done;
        logic [9:0] sl;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic t, input logic s, input logic p, input logic a,
                                input logic ct, input int ph, input int cs, input logic rst,
                                input logic bz, input logic dn, input int sl);
        vec_t v;
        v.tick = t; v.start = s; v.pause = p; v.abort = a; v.ct = ct;
        v.ph = 3'(ph); v.cs = 10'(cs); v.rst = rst; v.busy = bz; v.done = dn; v.sl = 10'(sl);
        return v;
    endfunction

    function automatic logic [9:0] exp_sl(input logic [9:0] v);
`ifdef REMAINING_TIME_EN
        return v;
`else
        if (v == 10'h3ff) return 10'd0;
        return 10'd0;
`endif
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int ph, input int cs, input logic rst,
                              input logic bz, input logic dn, input int sl);
        logic [25:0] act;
        logic [25:0] exp;
        act = {phase, counter_seconds, cnt_rst, busy, done, seconds_left};
        exp = {3'(ph), 10'(cs), rst, bz, dn, exp_sl(10'(sl))};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got ph=%0d cs=%0d rst=%b busy=%b done=%b sl=%0d expected ph=%0d cs=%0d rst=%b busy=%b done=%b sl=%0d",
                     name, act[25:23], act[22:13], act[12], act[11], act[10], act[9:0],
                     exp[25:23], exp[22:13], exp[12], exp[11], exp[10], exp[9:0]);
        end
    endtask

    // One clock: drive inputs, sample the combinational tick, then settle after the edge.
    task automatic step(input logic t, input logic s, input logic p, input logic a);
        tick = t; start = s; pause = p; abort = a;
        #1 ct_seen = cnt_tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_of[3];
        n_of[0] = 3; n_of[1] = 4; n_of[2] = 5;

        reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_state", 0, 0, 1'b1, 1'b0, 1'b0, 0);
        check_val("reset_cnt_tick", int'(cnt_tick), 0);
        reset = 1'b0;

        // tick start pause abort | cnt_tick | phase cs rst busy done sl
        vq.push_back(mk(1,1,0,0, 0, 1,3,1,1,0,3));   // start from IDLE
        vq.push_back(mk(1,0,0,0, 0, 1,3,0,1,0,3));   // entry-cycle tick dropped
        vq.push_back(mk(1,0,0,0, 1, 1,3,0,1,0,2));
        vq.push_back(mk(1,1,0,0, 1, 1,3,0,1,0,1));   // start while busy ignored
        vq.push_back(mk(0,0,0,0, 0, 1,3,0,1,0,1));
        vq.push_back(mk(1,0,0,0, 1, 2,4,1,1,0,4));   // A -> B
        vq.push_back(mk(1,0,0,0, 0, 2,4,0,1,0,4));
        vq.push_back(mk(1,0,0,0, 1, 2,4,0,1,0,3));
        vq.push_back(mk(1,0,0,0, 1, 2,4,0,1,0,2));
        vq.push_back(mk(1,1,0,1, 1, 0,0,1,0,0,0));   // abort + start in B
        vq.push_back(mk(1,0,0,0, 0, 0,0,1,0,0,0));
        vq.push_back(mk(0,1,0,0, 0, 1,3,1,1,0,3));
        vq.push_back(mk(0,0,0,0, 0, 1,3,0,1,0,3));
        vq.push_back(mk(1,0,0,0, 1, 1,3,0,1,0,2));
        vq.push_back(mk(1,0,0,0, 1, 1,3,0,1,0,1));
        vq.push_back(mk(1,0,1,0, 0, 1,3,0,1,0,1));   // paused with expiry pending
        vq.push_back(mk(1,0,1,0, 0, 1,3,0,1,0,1));
        vq.push_back(mk(0,0,0,0, 0, 1,3,0,1,0,1));
        vq.push_back(mk(1,0,0,0, 1, 2,4,1,1,0,4));
        vq.push_back(mk(1,0,0,0, 0, 2,4,0,1,0,4));
        vq.push_back(mk(1,0,0,0, 1, 2,4,0,1,0,3));
        vq.push_back(mk(1,0,0,0, 1, 2,4,0,1,0,2));
        vq.push_back(mk(1,0,0,0, 1, 2,4,0,1,0,1));
        vq.push_back(mk(1,0,0,0, 1, 3,5,1,1,0,5));   // B -> C
        vq.push_back(mk(1,0,0,0, 0, 3,5,0,1,0,5));
        vq.push_back(mk(1,0,0,0, 1, 3,5,0,1,0,4));
        vq.push_back(mk(1,0,0,0, 1, 3,5,0,1,0,3));
        vq.push_back(mk(1,0,0,0, 1, 3,5,0,1,0,2));
        vq.push_back(mk(1,0,0,0, 1, 3,5,0,1,0,1));
        vq.push_back(mk(1,0,0,0, 1, 4,0,1,0,1,0));   // C -> DONE with done pulse
        vq.push_back(mk(1,0,0,0, 0, 4,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0, 0, 4,0,1,0,0,0));
        vq.push_back(mk(0,1,0,0, 0, 1,3,1,1,0,3));   // start from DONE
        vq.push_back(mk(0,0,0,1, 0, 0,0,1,0,0,0));   // abort from A entry

        foreach (vq[i]) begin
            step(vq[i].tick, vq[i].start, vq[i].pause, vq[i].abort);
            check_val($sformatf("vec%0d_cnt_tick", i), int'(ct_seen), int'(vq[i].ct));
            check_outs($sformatf("vec%0d_outs", i), int'(vq[i].ph), int'(vq[i].cs),
                       vq[i].rst, vq[i].busy, vq[i].done, int'(vq[i].sl));
        end

        // Nominal run with a tick every fourth cycle.
        step(0,1,0,0);
        check_outs("nom_start", 1, 3, 1'b1, 1'b1, 1'b0, 3);
        for (int p = 0; p < 3; p++) begin
            for (int k = 1; k <= n_of[p]; k++) begin
                repeat (3) step(0,0,0,0);
                step(1,0,0,0);
                check_val($sformatf("nom_p%0d_t%0d_cnt_tick", p + 1, k), int'(ct_seen), 1);
                check_val($sformatf("nom_p%0d_t%0d_phase", p + 1, k), int'(phase),
                          (k < n_of[p]) ? p + 1 : p + 2);
            end
        end
        check_outs("nom_done_pulse", 4, 0, 1'b1, 1'b0, 1'b1, 0);
        step(0,0,0,0);
        check_outs("nom_done_end", 4, 0, 1'b1, 1'b0, 1'b0, 0);

        // Long pause across the expiry tick.
        step(1,1,0,0);
        check_outs("pause_start", 1, 3, 1'b1, 1'b1, 1'b0, 3);
        step(0,0,0,0);
        step(1,0,0,0);
        step(1,0,0,0);
        check_outs("pause_pre", 1, 3, 1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1,0,1,0);
            check_val($sformatf("pause%0d_cnt_tick", i), int'(ct_seen), 0);
            check_outs($sformatf("pause%0d_outs", i), 1, 3, 1'b0, 1'b1, 1'b0, 1);
        end
        step(1,0,0,0);
        check_outs("pause_release", 2, 4, 1'b1, 1'b1, 1'b0, 4);

        // Reset in the middle of phase C.
        step(0,0,0,0);
        repeat (4) step(1,0,0,0);
        check_outs("to_c", 3, 5, 1'b1, 1'b1, 1'b0, 5);
        step(1,0,0,0);
        step(1,0,0,0);
        check_outs("mid_c", 3, 5, 1'b0, 1'b1, 1'b0, 4);
        reset = 1'b1;
        step(1,0,0,0);
        reset = 1'b0;
        check_outs("reset_mid_c", 0, 0, 1'b1, 1'b0, 1'b0, 0);
        step(1,0,0,0);
        check_val("post_reset_cnt_tick", int'(ct_seen), 0);
        check_outs("post_reset_idle", 0, 0, 1'b1, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
